lcd_sram_fetch_arbiter: RTL and testbench
=========================================

// Module: lcd_sram_fetch_arbiter
// PURPOSE
//  Shares one single-port 16-bit async SRAM between the LCD pixel fetch path and a Nios write port.
//  - Prefetches RGB565 frame pixels into a small FIFO.
//  - Serves CPU writes in the gaps between fetches.
//  - Expands popped pixels to 8-bit R/G/B for the LCD timing controller's iRed/iGreen/iBlue.
//  - Sits between the Avalon slave glue, the SRAM pins and the LCD timing/data controller.
// PARAMETERS
//  FB_BASE     20'h00000  SRAM word address of pixel (0,0)
//  FRAME_PIX   19'd384000 pixels per frame (800x480), row-major
//  FIFO_DEPTH  16         pixel FIFO entries (power of 2)
//  LOW_WATER   6          level+inflight below this -> display has priority
// PORTS
//  Clock       in   1   50 MHz system clock
//  Resetn      in   1   async active-low reset
//  Enable      in   1   0 = synchronous clear of all state, SRAM idle
//  Frame_start in   1   1-cycle pulse at V_Count==0, H_Count==0; restarts fetch
//  Pix_pop     in   1   pulse, one cycle before each LCD oClock_en in the active area
//  oRed        out  8   popped pixel, R5 expanded {r,r[4:2]}
//  oGreen      out  8   G6 expanded {g,g[5:4]}
//  oBlue       out  8   B5 expanded {b,b[4:2]}
//  oUnderflow  out  1   sticky: pop on empty FIFO
//  oLevel      out  5   FIFO occupancy
//  wr_req      in   1   CPU write request, held until wr_ack
//  wr_addr     in   20  SRAM word address
//  wr_data     in   16  write data
//  wr_ack      out  1   1-cycle pulse: write driven this cycle
//  SRAM_ADDR   out  20  registered address
//  SRAM_DQ_out out  16  write data
//  SRAM_DQ_oe  out  1   1 = drive DQ
//  SRAM_DQ_in  in   16  read data
//  SRAM_WE_N   out  1   active-low write strobe
//  SRAM_OE_N   out  1   active-low output enable
//  SRAM_CE_N   out  1   tied 0 while Enable, 1 otherwise
// BEHAVIOUR
//  Reset/~Enable:
//   - all SRAM strobes = 1, DQ_oe = 0, addr = 0.
//   - oRGB = 0, oUnderflow = 0, wr_ack = 0, FIFO empty, state IDLE.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE -Frame_start-> RUN.
//   - RUN -fetched==FRAME_PIX-> DONE.
//   - DONE -Frame_start-> RUN.
//   - Any state -Frame_start-> RUN: pix counter=0, FIFO flushed, inflight tagged discard.
//  Per-cycle grant (one SRAM access/cycle), evaluated in order:
//   1. RUN and level+inflight < LOW_WATER -> display read.
//   2. wr_req and no wr_ack last cycle -> write.
//   3. RUN and level+inflight < FIFO_DEPTH -> display read.
//   4. Otherwise idle.
//  Read timing:
//   - Edge N registers addr = FB_BASE + pix_cnt, OE_N = 0.
//   - Edge N+1 captures SRAM_DQ_in and pushes it into the FIFO.
//   - inflight is 0/1; pix_cnt increments at grant.
//  Write timing:
//   - Registers addr/data with WE_N = 0, DQ_oe = 1 for exactly one cycle.
//   - wr_ack is asserted in that same cycle.
//   - wr_req must be seen low or re-evaluated after ack; no back-to-back writes to the same request.
//  Pixel output:
//   - Pix_pop with FIFO non-empty: head is registered to oRGB next cycle (latency 1).
//   - Pix_pop with FIFO empty: oRGB = 0 and oUnderflow set; oUnderflow is cleared only by reset/~Enable.
//   - No pop: oRGB holds its value.
//  Address arithmetic: 20-bit modulo add; pix_cnt 19-bit, never exceeds FRAME_PIX.
//  Boundaries:
//   - FIFO never overflows by construction (level+inflight check).
//   - Frame_start coincident with Pix_pop: flush wins, oRGB = 0, no underflow flag.
//   - Frame_start coincident with a write grant: the write completes and is acked.
//   - Data returning for a read issued before Frame_start is discarded.
//   - Enable falling mid-write: WE_N returns to 1 next edge, no ack issued.
// STRUCTURE
//  lcd_arb_pkg:
//   - arb_state_t enum {IDLE,RUN,DONE}
//   - grant_t enum {G_NONE,G_RD,G_WR}
//   - rgb565_expand() function
//   - FRAME_PIX default constant
//  Sub-module lcd_pixel_fifo: sync FIFO with push/pop/flush, 16-bit data, level output.
//  Top level holds the FSM, grant logic, SRAM pin registers and inflight/discard tracking.
// TESTING
//  - SRAM model preloaded with addr[15:0]; Frame_start, no pops -> 16 reads, then idle.
//    Check oLevel=16 and addresses 0..15.
//  - Steady pops every 2 cycles for 800 px:
//    oRGB follows 0,1,2.. expanded; oUnderflow stays 0; wr_req continuous still gets acks.
//  - wr_req held constant with FIFO full:
//    wr_ack every other cycle; WE_N low 1 cycle each; SRAM contents updated.
//  - Level forced to 3 while wr_req high: read wins the grant; write acked only once level+inflight >= LOW_WATER.
//  - Pix_pop issued before any Frame_start: oRGB=0, oUnderflow=1 and stays 1 after next Frame_start.
//  - Frame_start mid-frame with a read in flight:
//    FIFO level 0 next cycle; the stale word is not pushed; next read addr = FB_BASE.
//    After FRAME_PIX reads, state DONE and no further reads.

Source files
------------

// File: rtl/lcd_sram_fetch_arbiter_pkg.sv
// Shared types, widths and helpers for the LCD frame-buffer fetch / CPU write arbiter.
package lcd_arb_pkg;

    localparam int unsigned ADDR_W  = 20;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PIX_W   = 19;
    localparam int unsigned LEVEL_W = 5;

    localparam logic [PIX_W-1:0] FRAME_PIX_DEFAULT = 19'd384000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} arb_state_t;
    typedef enum logic [1:0] {G_NONE, G_RD, G_WR} grant_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Widen RGB565 by replicating the MSBs into the vacated low bits.
    function automatic rgb888_t rgb565_expand(input logic [DATA_W-1:0] p);
        rgb888_t c;
        c.r = {p[15:11], p[15:13]};
        c.g = {p[10:5],  p[10:9]};
        c.b = {p[4:0],   p[4:2]};
        return c;
    endfunction

endpackage

// File: rtl/lcd_sram_fetch_arbiter_if.sv
// CPU write port plus SRAM pin bundle; the arbiter sits on the slave side.
interface lcd_sram_fetch_arbiter_if;
    import lcd_arb_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_DQ_out;
    logic              SRAM_DQ_oe;
    logic [DATA_W-1:0] SRAM_DQ_in;
    logic              SRAM_WE_N;
    logic              SRAM_OE_N;
    logic              SRAM_CE_N;

    modport slave (
        input  wr_req, wr_addr, wr_data, SRAM_DQ_in,
        output wr_ack, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N
    );

    modport master (
        output wr_req, wr_addr, wr_data, SRAM_DQ_in,
        input  wr_ack, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N
    );

endinterface

// File: rtl/lcd_sram_fetch_arbiter_fifo.sv
// Synchronous pixel FIFO; flush overrides push/pop, head is read combinationally.
module lcd_pixel_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       head,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lcd_sram_fetch_arbiter.sv
// LCD pixel prefetch and CPU write arbiter for one shared single-port async SRAM.
// One SRAM access per cycle; display reads preempt writes while the FIFO runs low.
module lcd_sram_fetch_arbiter
    import lcd_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] FB_BASE    = '0,
    parameter logic [PIX_W-1:0]  FRAME_PIX  = FRAME_PIX_DEFAULT,
    parameter int unsigned       FIFO_DEPTH = 16,
    parameter int unsigned       LOW_WATER  = 6
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic                    Enable,
    input  logic                    Frame_start,
    input  logic                    Pix_pop,
    output logic [7:0]              oRed,
    output logic [7:0]              oGreen,
    output logic [7:0]              oBlue,
    output logic                    oUnderflow,
    output logic [LEVEL_W-1:0]      oLevel,
    lcd_sram_fetch_arbiter_if.slave bus
);
    localparam int unsigned FL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = FL_W + 1;

    arb_state_t        state;
    grant_t            grant_c;
    logic [PIX_W-1:0]  pix_cnt;
    logic              inflight;
    rgb888_t           rgb;
    logic [FL_W-1:0]   fifo_level;
    logic [DATA_W-1:0] fifo_head;
    logic [OCC_W-1:0]  occ_c;
    logic              rd_ok_c;
    logic              flush_c;
    logic              push_c;
    logic              pop_c;

    // Reads are held off during Frame_start, so the only stale word is the one landing on the flush edge.
    assign occ_c   = OCC_W'(fifo_level) + OCC_W'(inflight);
    assign rd_ok_c = Enable && (state == RUN) && !Frame_start;
    assign flush_c = !Enable || Frame_start;
    assign push_c  = inflight && !flush_c;
    assign pop_c   = Pix_pop && (fifo_level != '0) && !flush_c;

    always_comb begin
        grant_c = G_NONE;
        if (rd_ok_c && (occ_c < OCC_W'(LOW_WATER)))
            grant_c = G_RD;
        else if (Enable && bus.wr_req && !bus.wr_ack)
            grant_c = G_WR;
        else if (rd_ok_c && (occ_c < OCC_W'(FIFO_DEPTH)))
            grant_c = G_RD;
    end

    lcd_pixel_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo (
        .Clock  (Clock),
        .Resetn (Resetn),
        .flush  (flush_c),
        .push   (push_c),
        .pop    (pop_c),
        .din    (bus.SRAM_DQ_in),
        .head   (fifo_head),
        .level  (fifo_level)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn || !Enable) begin
            state           <= IDLE;
            pix_cnt         <= '0;
            inflight        <= 1'b0;
            rgb             <= '0;
            oUnderflow      <= 1'b0;
            bus.wr_ack      <= 1'b0;
            bus.SRAM_ADDR   <= '0;
            bus.SRAM_DQ_out <= '0;
            bus.SRAM_DQ_oe  <= 1'b0;
            bus.SRAM_WE_N   <= 1'b1;
            bus.SRAM_OE_N   <= 1'b1;
            bus.SRAM_CE_N   <= 1'b1;
        end else begin
            bus.SRAM_CE_N  <= 1'b0;
            bus.SRAM_WE_N  <= 1'b1;
            bus.SRAM_OE_N  <= 1'b1;
            bus.SRAM_DQ_oe <= 1'b0;
            bus.wr_ack     <= 1'b0;
            inflight       <= (grant_c == G_RD);

            case (grant_c)
                G_RD: begin
                    bus.SRAM_ADDR <= FB_BASE + ADDR_W'(pix_cnt);
                    bus.SRAM_OE_N <= 1'b0;
                    pix_cnt       <= pix_cnt + PIX_W'(1);
                end
                G_WR: begin
                    bus.SRAM_ADDR   <= bus.wr_addr;
                    bus.SRAM_DQ_out <= bus.wr_data;
                    bus.SRAM_DQ_oe  <= 1'b1;
                    bus.SRAM_WE_N   <= 1'b0;
                    bus.wr_ack      <= 1'b1;
                end
                default: ;
            endcase

            if (Frame_start) begin
                state   <= RUN;
                pix_cnt <= '0;
            end else if (state == RUN && grant_c == G_RD && pix_cnt == FRAME_PIX - PIX_W'(1)) begin
                state <= DONE;
            end

            // A pop coinciding with a frame restart is swallowed by the flush.
            if (Frame_start) begin
                if (Pix_pop) rgb <= '0;
            end else if (Pix_pop) begin
                if (pop_c) begin
                    rgb <= rgb565_expand(fifo_head);
                end else begin
                    rgb        <= '0;
                    oUnderflow <= 1'b1;
                end
            end
        end
    end

    assign oRed   = rgb.r;
    assign oGreen = rgb.g;
    assign oBlue  = rgb.b;
    assign oLevel = LEVEL_W'(fifo_level);

endmodule

// File: tb/tb_lcd_sram_fetch_arbiter.sv
// Bench for lcd_sram_fetch_arbiter: SRAM model preloaded with addr[15:0], random CPU writes
// and pop patterns, expected pixels/writes/addresses computed from the frame layout.
module tb_lcd_sram_fetch_arbiter;
    localparam int FRAME = 1000;
    localparam int LOWW  = 6;

    logic Clock = 1'b0;
    logic Resetn, Enable, Frame_start, Pix_pop;
    logic [7:0] oRed, oGreen, oBlue;
    logic oUnderflow;
    logic [4:0] oLevel;

    lcd_sram_fetch_arbiter_if bus();

    lcd_sram_fetch_arbiter #(
        .FB_BASE(20'h00000), .FRAME_PIX(19'(FRAME)), .FIFO_DEPTH(16), .LOW_WATER(LOWW)
    ) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Frame_start(Frame_start),
        .Pix_pop(Pix_pop), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oUnderflow(oUnderflow), .oLevel(oLevel), .bus(bus)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [65536];
    logic [15:0] model_mem [int];
    logic [19:0] rd_log [$];
    logic [35:0] wr_log [$];
    logic [35:0] exp_wr [$];
    int n_checks = 0, n_pass = 0, ack_cnt = 0, we_b2b = 0;
    bit cpu_on = 1'b0, we_prev = 1'b0;

    // Async SRAM: read data valid while OE_N low, write taken mid-cycle.
    assign bus.SRAM_DQ_in = (!bus.SRAM_OE_N && !bus.SRAM_CE_N) ? mem[bus.SRAM_ADDR[15:0]] : 16'h0000;

    always @(negedge Clock) begin
        if (!bus.SRAM_WE_N && !bus.SRAM_CE_N) begin
            mem[bus.SRAM_ADDR[15:0]] = bus.SRAM_DQ_out;
            wr_log.push_back({bus.SRAM_ADDR, bus.SRAM_DQ_out});
        end
        if (!bus.SRAM_WE_N && we_prev) we_b2b++;
        we_prev = !bus.SRAM_WE_N;
        if (!bus.SRAM_OE_N) rd_log.push_back(bus.SRAM_ADDR);
    end

    function automatic logic [23:0] exp_pix(input int k);
        int r, g, b;
        r = (k >> 11) & 31;
        g = (k >> 5) & 63;
        b = k & 31;
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    task automatic new_write();
        bus.wr_addr = 20'h08000 | 20'($urandom_range(0, 32767));
        bus.wr_data = 16'($urandom);
    endtask

    // Advance one cycle; the CPU model logs each acked write and presents the next one.
    task automatic step();
        @(posedge Clock);
        #1;
        if (cpu_on && bus.wr_ack) begin
            exp_wr.push_back({bus.wr_addr, bus.wr_data});
            model_mem[int'(bus.wr_addr)] = bus.wr_data;
            ack_cnt++;
            new_write();
        end
    endtask

    task automatic check_writes(input string tag);
        int bad = 0;
        bus.wr_req = 1'b0;
        step();
        step();
        n_checks++;
        if (wr_log.size() != exp_wr.size())
            $display("FAIL %s_count: got %0d writes, expected %0d", tag, wr_log.size(), exp_wr.size());
        else n_pass++;
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            if (wr_log[i] !== exp_wr[i]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL %s_order: %0d write cycles differ, expected 0", tag, bad);
        else n_pass++;
        bad = 0;
        foreach (model_mem[a]) if (mem[16'(a)] !== model_mem[a]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL %s_mem: %0d words differ, expected 0", tag, bad);
        else n_pass++;
        n_checks++;
        if (we_b2b != 0) $display("FAIL %s_we_b2b: got %0d back-to-back strobes, expected 0", tag, we_b2b);
        else n_pass++;
    endtask

    task automatic test_reset();
        Resetn = 1'b0; Enable = 1'b0; Frame_start = 1'b0; Pix_pop = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(posedge Clock);
        #1;
        n_checks++;
        if ({bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_CE_N, bus.SRAM_DQ_oe} !== 4'b1110)
            $display("FAIL reset_strobes: got %b expected 1110",
                     {bus.SRAM_WE_N, bus.SRAM_OE_N, bus.SRAM_CE_N, bus.SRAM_DQ_oe});
        else n_pass++;
        n_checks++;
        if (bus.SRAM_ADDR !== 20'h0) $display("FAIL reset_addr: got %h expected 0", bus.SRAM_ADDR);
        else n_pass++;
        n_checks++;
        if ({oRed, oGreen, oBlue} !== 24'h0) $display("FAIL reset_rgb: got %h expected 0", {oRed, oGreen, oBlue});
        else n_pass++;
        n_checks++;
        if ({oUnderflow, bus.wr_ack, oLevel} !== 7'h0)
            $display("FAIL reset_flags: got uf=%b ack=%b level=%0d expected 0/0/0", oUnderflow, bus.wr_ack, oLevel);
        else n_pass++;
        Resetn = 1'b1; Enable = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N} !== 3'b011)
            $display("FAIL idle_pins: got ce/oe/we=%b expected 011", {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N});
        else n_pass++;
    endtask

    task automatic test_underflow_before_frame();
        Pix_pop = 1'b1; step(); Pix_pop = 1'b0;
        n_checks++;
        if ({oUnderflow, oRed, oGreen, oBlue} !== 25'h1000000)
            $display("FAIL early_pop: got uf=%b rgb=%h expected uf=1 rgb=0", oUnderflow, {oRed, oGreen, oBlue});
        else n_pass++;
        step();
        Frame_start = 1'b1; step(); Frame_start = 1'b0;
        step();
        n_checks++;
        if (oUnderflow !== 1'b1) $display("FAIL uf_sticky: got %b expected 1", oUnderflow);
        else n_pass++;
        Enable = 1'b0; step();
        n_checks++;
        if ({oUnderflow, bus.SRAM_CE_N, oLevel} !== 7'b0100000)
            $display("FAIL disable_clear: got uf=%b ce_n=%b level=%0d expected 0/1/0", oUnderflow, bus.SRAM_CE_N, oLevel);
        else n_pass++;
        Enable = 1'b1; step();
    endtask

    task automatic test_prefetch();
        int bad = 0;
        rd_log.delete();
        Frame_start = 1'b1; step(); Frame_start = 1'b0;
        repeat (40) step();
        n_checks++;
        if (oLevel !== 5'd16) $display("FAIL prefetch_level: got %0d expected 16", oLevel);
        else n_pass++;
        n_checks++;
        if (rd_log.size() != 16) $display("FAIL prefetch_reads: got %0d expected 16", rd_log.size());
        else n_pass++;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 20'(i)) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL prefetch_addr: %0d addresses out of sequence, expected 0", bad);
        else n_pass++;
    endtask

    task automatic test_steady_pops();
        int bad = 0;
        exp_wr.delete(); wr_log.delete(); model_mem.delete();
        ack_cnt = 0; we_b2b = 0;
        cpu_on = 1'b1; new_write(); bus.wr_req = 1'b1;
        for (int k = 0; k < 800; k++) begin
            Pix_pop = 1'b1; step(); Pix_pop = 1'b0;
            n_checks++;
            if ({oRed, oGreen, oBlue} !== exp_pix(k)) begin
                if (bad < 10) $display("FAIL steady_pix%0d: got %h expected %h", k, {oRed, oGreen, oBlue}, exp_pix(k));
                bad++;
            end else n_pass++;
            step();
        end
        n_checks++;
        if (oUnderflow !== 1'b0) $display("FAIL steady_uf: got %b expected 0", oUnderflow);
        else n_pass++;
        n_checks++;
        if (ack_cnt < 200) $display("FAIL steady_acks: got %0d acks, expected at least 200", ack_cnt);
        else n_pass++;
        check_writes("steady_wr");
    endtask

    task automatic test_writes_full();
        logic [35:0] last;
        int c;
        repeat (20) step();
        n_checks++;
        if (oLevel !== 5'd16) $display("FAIL full_level: got %0d expected 16", oLevel);
        else n_pass++;
        exp_wr.delete(); wr_log.delete(); we_b2b = 0;
        new_write(); bus.wr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if ({bus.wr_ack, bus.SRAM_WE_N, bus.SRAM_DQ_oe} !== {(i % 2 == 0), (i % 2 != 0), (i % 2 == 0)})
                $display("FAIL full_ack%0d: got ack/we_n/oe=%b expected ack=%0d", i,
                         {bus.wr_ack, bus.SRAM_WE_N, bus.SRAM_DQ_oe}, (i % 2 == 0));
            else n_pass++;
            if (i % 2 == 0 && exp_wr.size() > 0) begin
                last = exp_wr[$];
                n_checks++;
                if ({bus.SRAM_ADDR, bus.SRAM_DQ_out} !== last)
                    $display("FAIL full_pins%0d: got %h expected %h", i, {bus.SRAM_ADDR, bus.SRAM_DQ_out}, last);
                else n_pass++;
            end
        end
        // Restart the frame in a cycle whose grant is a write.
        rd_log.delete();
        Frame_start = 1'b1; step(); Frame_start = 1'b0;
        n_checks++;
        if ({bus.wr_ack, oLevel} !== 6'b100000)
            $display("FAIL fs_write: got ack=%b level=%0d expected ack=1 level=0", bus.wr_ack, oLevel);
        else n_pass++;
        c = 0;
        do begin step(); c++; end while (!bus.wr_ack && c < 30);
        n_checks++;
        if (rd_log.size() != LOWW || oLevel !== 5'(LOWW))
            $display("FAIL low_water: got %0d reads level=%0d before ack, expected %0d/%0d", rd_log.size(), oLevel, LOWW, LOWW);
        else n_pass++;
        n_checks++;
        if (rd_log.size() == 0 || rd_log[0] !== 20'h0 || rd_log[rd_log.size()-1] !== 20'(rd_log.size() - 1))
            $display("FAIL low_water_addr: got first=%h n=%0d expected sequence from 0", rd_log.size() ? rd_log[0] : 20'hfffff, rd_log.size());
        else n_pass++;
        check_writes("full_wr");
        cpu_on = 1'b0;
    endtask

    task automatic test_frame_restart();
        int got = 0, bad = 0, c;
        repeat (20) step();
        Pix_pop = 1'b1; step(); Pix_pop = 1'b0;
        n_checks++;
        if ({oRed, oGreen, oBlue} !== exp_pix(0)) $display("FAIL rs_pix0: got %h expected %h", {oRed, oGreen, oBlue}, exp_pix(0));
        else n_pass++;
        Pix_pop = 1'b1; step(); Pix_pop = 1'b0;
        n_checks++;
        if ({oRed, oGreen, oBlue} !== exp_pix(1)) $display("FAIL rs_pix1: got %h expected %h", {oRed, oGreen, oBlue}, exp_pix(1));
        else n_pass++;
        c = 0;
        while (bus.SRAM_OE_N && c < 10) begin step(); c++; end
        n_checks++;
        if (bus.SRAM_OE_N !== 1'b0) $display("FAIL rs_inflight: got oe_n=%b expected 0 within 10 cycles", bus.SRAM_OE_N);
        else n_pass++;
        Frame_start = 1'b1; Pix_pop = 1'b1; step(); Frame_start = 1'b0; Pix_pop = 1'b0;
        n_checks++;
        if ({oLevel, oUnderflow, oRed, oGreen, oBlue} !== 30'h0)
            $display("FAIL rs_flush: got level=%0d uf=%b rgb=%h expected 0/0/0", oLevel, oUnderflow, {oRed, oGreen, oBlue});
        else n_pass++;
        rd_log.delete();
        for (c = 0; c < 6000 && got < FRAME; c++) begin
            Pix_pop = (oLevel != 0) && ($urandom_range(0, 3) != 0);
            step();
            if (Pix_pop) begin
                n_checks++;
                if ({oRed, oGreen, oBlue} !== exp_pix(got)) begin
                    if (bad < 10) $display("FAIL rs_pix%0d: got %h expected %h", got, {oRed, oGreen, oBlue}, exp_pix(got));
                    bad++;
                end else n_pass++;
                got++;
            end
            Pix_pop = 1'b0;
        end
        n_checks++;
        if (got != FRAME) $display("FAIL rs_frame_pixels: got %0d expected %0d", got, FRAME);
        else n_pass++;
        repeat (30) step();
        bad = 0;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] !== 20'(i)) bad++;
        n_checks++;
        if (rd_log.size() != FRAME || bad != 0)
            $display("FAIL rs_reads: got %0d reads with %0d out of sequence, expected %0d/0", rd_log.size(), bad, FRAME);
        else n_pass++;
        n_checks++;
        if ({bus.SRAM_OE_N, oUnderflow, oLevel} !== 7'b1000000)
            $display("FAIL rs_done: got oe_n=%b uf=%b level=%0d expected 1/0/0", bus.SRAM_OE_N, oUnderflow, oLevel);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        int c = 0, acks;
        cpu_on = 1'b1; new_write(); bus.wr_req = 1'b1;
        while (bus.SRAM_WE_N && c < 10) begin step(); c++; end
        n_checks++;
        if (bus.SRAM_WE_N !== 1'b0) $display("FAIL ed_write: got we_n=%b expected 0 within 10 cycles", bus.SRAM_WE_N);
        else n_pass++;
        Enable = 1'b0; step();
        acks = ack_cnt;
        n_checks++;
        if ({bus.SRAM_WE_N, bus.wr_ack, bus.SRAM_CE_N, bus.SRAM_DQ_oe} !== 4'b1010)
            $display("FAIL ed_drop: got we_n/ack/ce_n/oe=%b expected 1010",
                     {bus.SRAM_WE_N, bus.wr_ack, bus.SRAM_CE_N, bus.SRAM_DQ_oe});
        else n_pass++;
        repeat (4) step();
        n_checks++;
        if (ack_cnt != acks) $display("FAIL ed_no_ack: got %0d acks while disabled, expected 0", ack_cnt - acks);
        else n_pass++;
        bus.wr_req = 1'b0; cpu_on = 1'b0; Enable = 1'b1;
        step();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
        test_reset();
        test_underflow_before_frame();
        test_prefetch();
        test_steady_pops();
        test_writes_full();
        test_frame_restart();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
